// File: rtl/sonic_echo_model_if.sv
// rtl/sonic_echo_model_if.sv - Trig/Echo ranging pins plus control and status of the echo emulator
interface sonic_echo_model_if;
    logic        Trig;
    logic        en;
    logic [11:0] dist_cm;
    logic        Echo;
    logic        busy;
    logic        trig_err;
    logic [2:0]  state;

    // Ranging front end: fires Trig, programs distance, watches Echo.
    modport master (
        output Trig,
        output en,
        output dist_cm,
        input  Echo,
        input  busy,
        input  trig_err,
        input  state
    );

    // Emulated sensor.
    modport slave (
        input  Trig,
        input  en,
        input  dist_cm,
        output Echo,
        output busy,
        output trig_err,
        output state
    );
endinterface

// File: rtl/sonic_echo_model.sv
// rtl/sonic_echo_model.sv - HC-SR04 style ultrasonic sensor emulator answering Trig with a distance-coded Echo
module sonic_echo_model #(
    parameter int CLK_PER_US  = 50,
    parameter int MIN_TRIG_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = 58,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 1000,
    parameter int CNT_W       = 21
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    sonic_echo_model_if.slave    bus
);

    localparam int T_MIN      = MIN_TRIG_US * CLK_PER_US;
    localparam int T_BURST    = BURST_US * CLK_PER_US;
    localparam int T_HOLD     = HOLDOFF_US * CLK_PER_US;
    localparam int T_TIMEOUT  = TIMEOUT_US * CLK_PER_US;
    localparam int CYC_PER_CM = US_PER_CM * CLK_PER_US;

    localparam logic [CNT_W-1:0] TMIN_C    = CNT_W'(T_MIN);
    localparam logic [CNT_W-1:0] TBURST_M1 = CNT_W'(T_BURST - 1);
    localparam logic [CNT_W-1:0] THOLD_M1  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] TTO_C     = CNT_W'(T_TIMEOUT);
    localparam logic [31:0]      MAX_CM_U  = 32'(MAX_CM);
    localparam logic [31:0]      CPC_U     = 32'(CYC_PER_CM);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEAS    = 3'd1,
        S_BURST   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] w_len;
    logic             trig_s1;
    logic             trig_s2;
    logic             trig_s2_d;
    logic             trig_rise;
    logic             trig_fall;
    logic [11:0]      d_eff;
    logic [31:0]      prod;
    logic [CNT_W-1:0] w_calc;

    // Two-flop synchronizer plus one history flop for edge detection; all
    // preset high so a Trig already asserted at reset release is not an edge.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            trig_s1   <= 1'b1;
            trig_s2   <= 1'b1;
            trig_s2_d <= 1'b1;
        end else begin
            trig_s1   <= bus.Trig;
            trig_s2   <= trig_s1;
            trig_s2_d <= trig_s2;
        end
    end

    assign trig_rise = trig_s2 & ~trig_s2_d;
    assign trig_fall = ~trig_s2 & trig_s2_d;

    // Echo width for the distance currently on the pins; zero distance is
    // reported as 1 cm and anything past range as the no-object timeout.
    always_comb begin
        d_eff  = (bus.dist_cm == 12'd0) ? 12'd1 : bus.dist_cm;
        prod   = 32'(d_eff) * CPC_U;
        w_calc = CNT_W'(prod);
        if (32'(bus.dist_cm) > MAX_CM_U) begin
            w_calc = TTO_C;
        end
    end

    // Measurement sequencer: qualify Trig width, then burst delay, echo
    // pulse and recovery holdoff, each timed by the shared down counter.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            st           <= S_IDLE;
            cnt          <= '0;
            w_len        <= '0;
            bus.Echo     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.trig_err <= 1'b0;
        end else begin
            bus.trig_err <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (trig_rise && bus.en) begin
                        st  <= S_MEAS;
                        cnt <= CNT_W'(1);
                    end
                end
                S_MEAS: begin
                    if (trig_fall) begin
                        if (cnt >= TMIN_C) begin
                            st       <= S_BURST;
                            w_len    <= w_calc;
                            cnt      <= TBURST_M1;
                            bus.busy <= 1'b1;
                        end else begin
                            st           <= S_IDLE;
                            cnt          <= '0;
                            bus.trig_err <= 1'b1;
                        end
                    end else if (trig_s2 && cnt < TMIN_C) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_BURST: begin
                    if (cnt == '0) begin
                        st       <= S_ECHO;
                        cnt      <= w_len - CNT_W'(1);
                        bus.Echo <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ECHO: begin
                    if (cnt == '0) begin
                        st       <= S_HOLDOFF;
                        cnt      <= THOLD_M1;
                        bus.Echo <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_HOLDOFF: begin
                    if (cnt == '0) begin
                        st       <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    st       <= S_IDLE;
                    cnt      <= '0;
                    bus.Echo <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state = st;

endmodule

// File: tb/tb_sonic_echo_model.sv
// tb/tb_sonic_echo_model.sv - directed bench for sonic_echo_model with scaled timing parameters
module tb_sonic_echo_model;

    localparam int TMIN = 20;   // 10 us * 2 clk/us
    localparam int TB   = 40;   // 20 us * 2
    localparam int TH   = 100;  // 50 us * 2

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sonic_echo_model_if bus ();

    sonic_echo_model #(
        .CLK_PER_US (2),
        .MIN_TRIG_US(10),
        .BURST_US   (20),
        .US_PER_CM  (3),
        .MAX_CM     (400),
        .TIMEOUT_US (1500),
        .HOLDOFF_US (50),
        .CNT_W      (21)
    ) dut (
        .clk_50m(clk),
        .rst    (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One accepted measurement; exact edge positions relative to the Trig fall.
    task automatic measure(input string tag, input logic [11:0] d, input int exp_w,
                           input bit disturb, input bit retrig);
        int w;
        bus.dist_cm = d;
        bus.Trig = 1'b1;
        tick(TMIN);
        bus.Trig = 1'b0;
        tick(3);
        chk({tag, " burst state"}, 32'(bus.state), 32'd2);
        chk({tag, " burst busy"}, 32'(bus.busy), 32'd1);
        tick(TB - 1);
        chk({tag, " echo before rise"}, 32'(bus.Echo), 32'd0);
        tick(1);
        chk({tag, " echo rise"}, 32'(bus.Echo), 32'd1);
        chk({tag, " echo state"}, 32'(bus.state), 32'd3);
        if (disturb) begin
            bus.Trig = 1'b1;
            bus.dist_cm = 12'd401;
        end
        w = 1;
        while (w < 4000) begin
            tick(1);
            if (bus.Echo !== 1'b1) break;
            w++;
        end
        chk({tag, " echo width"}, 32'(w), 32'(exp_w));
        chk({tag, " holdoff state"}, 32'(bus.state), 32'd4);
        chk({tag, " holdoff busy"}, 32'(bus.busy), 32'd1);
        tick(TH - 2);
        if (retrig) bus.Trig = 1'b1;
        tick(1);
        chk({tag, " holdoff end"}, 32'(bus.state), 32'd4);
        tick(1);
        chk({tag, " idle state"}, 32'(bus.state), 32'd0);
        chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.Trig = 1'b1;
        bus.en = 1'b1;
        bus.dist_cm = 12'd0;
        tick(3);
        chk("reset echo", 32'(bus.Echo), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset trig_err", 32'(bus.trig_err), 32'd0);
        chk("reset state", 32'(bus.state), 32'd0);
        rst = 1'b0;
        tick(10);
        chk("trig high at release", 32'(bus.state), 32'd0);
        bus.Trig = 1'b0;
        tick(5);

        measure("d100", 12'd100, 600, 1'b0, 1'b0);

        bus.Trig = 1'b1;
        tick(TMIN - 1);
        bus.Trig = 1'b0;
        tick(2);
        chk("short err early", 32'(bus.trig_err), 32'd0);
        tick(1);
        chk("short err pulse", 32'(bus.trig_err), 32'd1);
        chk("short state", 32'(bus.state), 32'd0);
        tick(1);
        chk("short err single", 32'(bus.trig_err), 32'd0);
        tick(TB + 5);
        chk("short no echo", 32'(bus.Echo), 32'd0);
        chk("short not busy", 32'(bus.busy), 32'd0);

        measure("d0", 12'd0, 6, 1'b0, 1'b0);
        measure("d400", 12'd400, 2400, 1'b0, 1'b0);
        measure("d401", 12'd401, 3000, 1'b0, 1'b0);
        measure("d4095", 12'd4095, 3000, 1'b0, 1'b0);

        measure("disturb", 12'd50, 300, 1'b1, 1'b0);
        tick(30);
        chk("held trig no start", 32'(bus.state), 32'd0);
        bus.Trig = 1'b0;
        tick(3);

        bus.en = 1'b0;
        bus.Trig = 1'b1;
        tick(TMIN + 5);
        bus.Trig = 1'b0;
        tick(3);
        chk("en0 idle state", 32'(bus.state), 32'd0);
        tick(TB + 5);
        chk("en0 no echo", 32'(bus.Echo), 32'd0);
        chk("en0 not busy", 32'(bus.busy), 32'd0);
        bus.en = 1'b1;

        bus.dist_cm = 12'd1;
        bus.Trig = 1'b1;
        tick(TMIN);
        bus.Trig = 1'b0;
        tick(3);
        chk("en drop burst", 32'(bus.state), 32'd2);
        bus.en = 1'b0;
        tick(TB);
        chk("en drop echo", 32'(bus.Echo), 32'd1);
        tick(6 + TH);
        chk("en drop idle", 32'(bus.state), 32'd0);
        chk("en drop busy", 32'(bus.busy), 32'd0);
        bus.en = 1'b1;

        measure("retrig", 12'd2, 12, 1'b0, 1'b1);
        tick(1);
        chk("retrig accepted", 32'(bus.state), 32'd1);
        tick(TMIN);
        bus.Trig = 1'b0;
        tick(3);
        chk("retrig burst", 32'(bus.state), 32'd2);
        tick(TB + 12 + TH);
        chk("retrig idle", 32'(bus.state), 32'd0);

        bus.dist_cm = 12'd100;
        bus.Trig = 1'b1;
        tick(TMIN);
        bus.Trig = 1'b0;
        tick(3 + TB + 10);
        chk("pre-reset echo", 32'(bus.Echo), 32'd1);
        bus.Trig = 1'b1;
        rst = 1'b1;
        tick(1);
        chk("mid rst echo", 32'(bus.Echo), 32'd0);
        chk("mid rst state", 32'(bus.state), 32'd0);
        chk("mid rst busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick(20);
        chk("post rst held trig", 32'(bus.state), 32'd0);
        chk("post rst no echo", 32'(bus.Echo), 32'd0);
        bus.Trig = 1'b0;
        tick(5);
        measure("after rst", 12'd0, 6, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
